// File: rtl/core_pkg.sv
// core_pkg: shared loader state encoding and instruction width.
package core_pkg;
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, RUN, ERROR} loader_state_t;
  localparam int INSTR_W = 32;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: assembles four little-endian stream bytes into one instruction word.
module byte_packer
  import core_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [7:0]         byte_i,
  output logic [INSTR_W-1:0] word_o,
  output logic               word_done_o
);
  logic [1:0]         idx_q;
  logic [INSTR_W-1:0] word_q;
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (en_i) begin
      word_q[8*idx_q+:8] <= byte_i;
      idx_q              <= idx_q + 2'd1;
    end
  end
  assign word_o      = word_q;
  assign word_done_o = en_i && idx_q == 2'd3;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot loader streaming bytes into IMEM words, verifying a trailing XOR checksum before releasing the core.
module imem_loader
  import core_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_req,
  input  logic [15:0]        load_len,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic [INSTR_W-1:0] Imem_write_instr,
  output logic               Imem_write_en,
  output logic [ADDR_W-1:0]  Imem_write_addr,
  output logic               start,
  output logic               busy,
  output logic               error
);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;
  loader_state_t      state_q, state_d;
  logic [15:0]        len_q, len_d, cnt_q, cnt_d;
  logic [INSTR_W-1:0] csum_q, csum_d, word;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               accept, xfer, word_done, in_write;
  assign accept = load_req && (state_q inside {IDLE, RUN, ERROR});
  assign xfer   = byte_valid && state_q == RECV;
  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (accept),
    .en_i       (xfer),
    .byte_i     (byte_in),
    .word_o     (word),
    .word_done_o(word_done)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
    end
  end
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    tmo_d   = tmo_q;
    if (accept) begin
      len_d   = load_len;
      cnt_d   = '0;
      csum_d  = '0;
      tmo_d   = '0;
      state_d = ({1'b0, load_len} > MAX_LEN) ? ERROR : RECV;
    end else begin
      case (state_q)
        RECV: begin
          if (xfer) begin
            tmo_d = '0;
            if (word_done) state_d = (cnt_q < len_q) ? WRITE : CHECK;
          end else begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_d == TMO_LIM) state_d = ERROR;
          end
        end
        WRITE: begin
          csum_d  = csum_q ^ word;
          cnt_d   = cnt_q + 16'd1;
          state_d = RECV;
        end
        CHECK:   state_d = (word == csum_q) ? RUN : ERROR;
        default: ;
      endcase
    end
  end
  // The strobe is masked by reset so a write cycle hit by reset never reaches IMEM.
  assign in_write         = state_q == WRITE;
  assign Imem_write_en    = in_write && !reset;
  assign Imem_write_instr = in_write ? word : '0;
  assign Imem_write_addr  = in_write ? cnt_q[ADDR_W-1:0] : '0;
  assign byte_ready       = state_q == RECV;
  assign busy             = state_q inside {RECV, WRITE, CHECK};
  assign start            = state_q == RUN;
  assign error            = state_q == ERROR;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard-driven bench for the IMEM boot loader.
module tb_imem_loader;
  logic        clk = 0, reset = 1, load_req = 0, byte_valid = 0;
  logic [15:0] load_len = 0;
  logic [7:0]  byte_in = 0;
  logic        byte_ready, Imem_write_en, start, busy, error;
  logic [31:0] Imem_write_instr;
  logic [9:0]  Imem_write_addr;
  int vectors = 0, miscompares = 0, wcount = 0;
  logic [41:0] exp_q[$];
  imem_loader #(.ADDR_W(10), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .load_req(load_req), .load_len(load_len),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .Imem_write_instr(Imem_write_instr), .Imem_write_en(Imem_write_en),
    .Imem_write_addr(Imem_write_addr), .start(start), .busy(busy), .error(error)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (Imem_write_en) begin
      logic [41:0] e;
      wcount++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", Imem_write_addr, Imem_write_instr);
      end else begin
        e = exp_q.pop_front();
        if ({Imem_write_addr, Imem_write_instr} !== e || start !== 1'b0) begin
          miscompares++;
          $display("FAIL imem_write: got addr=%0d data=%h start=%b, required addr=%0d data=%h start=0",
                   Imem_write_addr, Imem_write_instr, start, e[41:32], e[31:0]);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic pulse_load(input logic [15:0] len);
    load_req = 1; load_len = len;
    tick();
    load_req = 0;
  endtask
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_in = b; byte_valid = 1;
    while (!byte_ready && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      vectors++; miscompares++;
      $display("FAIL byte_ready_wait: got ready=0 after %0d cycles, required ready=1", n);
    end
    tick();
    byte_valid = 0;
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i+:8]);
  endtask
  task automatic test_reset();
    reset = 1;
    repeat (3) tick();
    vectors++;
    if ({start, busy, error, byte_ready, Imem_write_en} !== 5'b0 || Imem_write_instr !== 32'h0 || Imem_write_addr !== 10'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got start=%b busy=%b error=%b ready=%b we=%b instr=%h addr=%0d, required all 0",
               start, busy, error, byte_ready, Imem_write_en, Imem_write_instr, Imem_write_addr);
    end
    reset = 0;
    tick();
    vectors++;
    if ({start, busy, error, byte_ready} !== 4'b0) begin
      miscompares++;
      $display("FAIL idle_outputs: got start=%b busy=%b error=%b ready=%b, required 0000", start, busy, error, byte_ready);
    end
  endtask
  task automatic test_basic_load();
    int w0 = wcount;
    pulse_load(2);
    vectors++;
    if (busy !== 1'b1 || byte_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL recv_entry: got busy=%b ready=%b, required 1 1", busy, byte_ready);
    end
    exp_q.push_back({10'd0, 32'h00000013});
    exp_q.push_back({10'd1, 32'h00100093});
    send_word(32'h00000013);
    vectors++;
    if (byte_ready !== 1'b0 || Imem_write_en !== 1'b1) begin
      miscompares++;
      $display("FAIL write_cycle: got ready=%b we=%b, required ready=0 we=1", byte_ready, Imem_write_en);
    end
    tick();
    vectors++;
    if (byte_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL write_to_ready: got ready=%b, required 1", byte_ready);
    end
    send_word(32'h00100093);
    send_word(32'h00100080);
    vectors++;
    if (start !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL check_cycle: got start=%b busy=%b, required start=0 busy=1", start, busy);
    end
    tick();
    vectors++;
    if (start !== 1'b1 || error !== 1'b0 || busy !== 1'b0 || wcount - w0 != 2 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL good_checksum: got start=%b error=%b busy=%b writes=%0d pending=%0d, required 1 0 0 2 0",
               start, error, busy, wcount - w0, exp_q.size());
    end
  endtask
  task automatic test_bad_checksum();
    int w0 = wcount;
    pulse_load(2);
    vectors++;
    if (start !== 1'b0) begin
      miscompares++;
      $display("FAIL start_drop: got start=%b, required 0", start);
    end
    exp_q.push_back({10'd0, 32'h00000013});
    exp_q.push_back({10'd1, 32'h00100093});
    send_word(32'h00000013);
    send_word(32'h00100093);
    send_word(32'h00100081);
    tick();
    repeat (3) tick();
    vectors++;
    if (start !== 1'b0 || error !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0 || wcount - w0 != 2) begin
      miscompares++;
      $display("FAIL bad_checksum: got start=%b error=%b busy=%b ready=%b writes=%0d, required 0 1 0 0 2",
               start, error, busy, byte_ready, wcount - w0);
    end
  endtask
  task automatic test_len_zero();
    int w0 = wcount;
    pulse_load(0);
    vectors++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL error_clear: got error=%b busy=%b, required 0 1", error, busy);
    end
    send_word(32'h0);
    tick();
    vectors++;
    if (start !== 1'b1 || error !== 1'b0 || wcount != w0) begin
      miscompares++;
      $display("FAIL len_zero: got start=%b error=%b writes=%0d, required 1 0 0", start, error, wcount - w0);
    end
  endtask
  task automatic test_timeout();
    int w0 = wcount;
    pulse_load(1);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (14) tick();
    vectors++;
    if (error !== 1'b0 || byte_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_early: got error=%b ready=%b, required 0 1", error, byte_ready);
    end
    tick();
    vectors++;
    if (error !== 1'b1 || byte_ready !== 1'b0 || busy !== 1'b0 || wcount != w0) begin
      miscompares++;
      $display("FAIL timeout_fire: got error=%b ready=%b busy=%b writes=%0d, required 1 0 0 0",
               error, byte_ready, busy, wcount - w0);
    end
    byte_valid = 1; byte_in = 8'h33;
    repeat (3) tick();
    byte_valid = 0;
    vectors++;
    if (error !== 1'b1 || byte_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL error_sticky: got error=%b ready=%b, required 1 0", error, byte_ready);
    end
  endtask
  task automatic test_over_length();
    int w0 = wcount;
    pulse_load(16'd1025);
    vectors++;
    if (error !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL over_length: got error=%b busy=%b ready=%b, required 1 0 0", error, busy, byte_ready);
    end
    byte_valid = 1; byte_in = 8'h55;
    repeat (6) tick();
    byte_valid = 0;
    vectors++;
    if (wcount != w0 || error !== 1'b1) begin
      miscompares++;
      $display("FAIL over_length_nowrite: got writes=%0d error=%b, required 0 1", wcount - w0, error);
    end
  endtask
  task automatic test_reset_in_write();
    int w0 = wcount;
    pulse_load(1);
    send_word(32'hCAFEF00D);
    reset = 1;
    #1;
    vectors++;
    if (Imem_write_en !== 1'b0) begin
      miscompares++;
      $display("FAIL write_suppress: got we=%b, required 0", Imem_write_en);
    end
    tick();
    reset = 0;
    vectors++;
    if ({start, busy, error, byte_ready, Imem_write_en} !== 5'b0 || Imem_write_instr !== 32'h0 || wcount != w0) begin
      miscompares++;
      $display("FAIL reset_midload: got start=%b busy=%b error=%b ready=%b we=%b instr=%h writes=%0d, required all 0",
               start, busy, error, byte_ready, Imem_write_en, Imem_write_instr, wcount - w0);
    end
    exp_q.push_back({10'd0, 32'hCAFEF00D});
    pulse_load(1);
    send_word(32'hCAFEF00D);
    send_word(32'hCAFEF00D);
    tick();
    vectors++;
    if (start !== 1'b1 || wcount - w0 != 1) begin
      miscompares++;
      $display("FAIL reload_after_reset: got start=%b writes=%0d, required 1 1", start, wcount - w0);
    end
  endtask
  task automatic test_back_to_back();
    int w0 = wcount;
    pulse_load(1);
    vectors++;
    if (start !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL run_reload: got start=%b busy=%b, required 0 1", start, busy);
    end
    exp_q.push_back({10'd0, 32'hDEADBEEF});
    send_byte(8'hEF);
    pulse_load(5);
    send_byte(8'hBE);
    send_byte(8'hAD);
    send_byte(8'hDE);
    send_word(32'hA5A5A5A5 ^ 32'hA5A5A5A5 ^ 32'hDEADBEEF);
    tick();
    vectors++;
    if (start !== 1'b1 || error !== 1'b0 || wcount - w0 != 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL reload_done: got start=%b error=%b writes=%0d pending=%0d, required 1 0 1 0",
               start, error, wcount - w0, exp_q.size());
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_basic_load();
    test_bad_checksum();
    test_len_zero();
    test_timeout();
    test_over_length();
    test_reset_in_write();
    test_back_to_back();
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
